// File: rtl/rat_io_timer.sv
// Peripheral-side port-bus responder for the RAT MCU: LED register, 16-bit
// down-counting timer, synchronized switch inputs and a level interrupt.
module rat_io_timer #(
  parameter logic [7:0] SW_ID       = 8'h20,
  parameter logic [7:0] LED_ID      = 8'h40,
  parameter logic [7:0] TMR_LO_ID   = 8'h31,
  parameter logic [7:0] TMR_HI_ID   = 8'h32,
  parameter logic [7:0] TMR_CTRL_ID = 8'h33,
  parameter logic [7:0] TMR_STAT_ID = 8'h34
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  input  logic [7:0] SWITCHES,
  output logic [7:0] IN_PORT,
  output logic [7:0] LEDS,
  output logic       INTR
);

  localparam int unsigned CNT_W = 16;

  logic [7:0]       reload_lo;
  logic [7:0]       reload_hi;
  logic [7:0]       ctrl;
  logic [CNT_W-1:0] count;
  logic [1:0]       pending;
  logic [7:0]       sw_meta;
  logic [7:0]       sw_sync;
  logic [7:0]       sw_prev;

  logic             wr_led;
  logic             wr_lo;
  logic             wr_hi;
  logic             wr_ctrl;
  logic             wr_stat;
  logic             load;
  logic             tmr_expire;
  logic             sw_rise;
  logic [1:0]       pending_next;
  logic [CNT_W-1:0] reload;

  assign wr_led  = IO_STRB && (PORT_ID == LED_ID);
  assign wr_lo   = IO_STRB && (PORT_ID == TMR_LO_ID);
  assign wr_hi   = IO_STRB && (PORT_ID == TMR_HI_ID);
  assign wr_ctrl = IO_STRB && (PORT_ID == TMR_CTRL_ID);
  assign wr_stat = IO_STRB && (PORT_ID == TMR_STAT_ID);

  assign reload     = {reload_hi, reload_lo};
  assign load       = wr_ctrl && OUT_PORT[0];
  assign tmr_expire = ctrl[0] && !load && (count == '0);
  assign sw_rise    = |(sw_sync & ~sw_prev);

  // Clearing by a status write loses to a same-cycle set event.
  assign pending_next = (wr_stat ? 2'b00 : pending) | {sw_rise, tmr_expire};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS      <= 8'h00;
      reload_lo <= 8'h00;
      reload_hi <= 8'h00;
      ctrl      <= 8'h00;
      count     <= '0;
      pending   <= 2'b00;
      sw_meta   <= 8'h00;
      sw_sync   <= 8'h00;
      sw_prev   <= 8'h00;
      INTR      <= 1'b0;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
      sw_prev <= sw_sync;

      if (wr_led) LEDS <= OUT_PORT;
      if (wr_lo)  reload_lo <= OUT_PORT;
      if (wr_hi)  reload_hi <= OUT_PORT;

      // A CTRL write overrides the one-shot self-disable in the same cycle.
      if (wr_ctrl) begin
        ctrl <= OUT_PORT;
      end else if (tmr_expire && !ctrl[1]) begin
        ctrl[0] <= 1'b0;
      end

      if (load) begin
        count <= reload;
      end else if (ctrl[0]) begin
        if (count != '0) begin
          count <= count - CNT_W'(1);
        end else if (ctrl[1]) begin
          count <= reload;
        end
      end

      pending <= pending_next;
      INTR    <= (pending[0] & ctrl[2]) | (pending[1] & ctrl[3]);
    end
  end

  // Zero-latency read mux; reads have no side effects.
  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      SW_ID:       IN_PORT = sw_sync;
      LED_ID:      IN_PORT = LEDS;
      TMR_LO_ID:   IN_PORT = reload_lo;
      TMR_HI_ID:   IN_PORT = reload_hi;
      TMR_CTRL_ID: IN_PORT = ctrl;
      TMR_STAT_ID: IN_PORT = {6'b000000, pending};
      default:     IN_PORT = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_rat_io_timer.sv
// Directed bench for rat_io_timer: register vector table plus hand-built
// timer, switch-edge, status-clear and reset sequences.
module tb_rat_io_timer;

  logic       CLK;
  logic       RESET;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] SWITCHES;
  logic [7:0] IN_PORT;
  logic [7:0] LEDS;
  logic       INTR;

  int checks = 0;
  int errors = 0;

  rat_io_timer dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .SWITCHES(SWITCHES), .IN_PORT(IN_PORT),
    .LEDS(LEDS), .INTR(INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       strb;
    logic [7:0] id;
    logic [7:0] data;
    logic [7:0] exp_in;
    logic [7:0] exp_leds;
    logic       exp_intr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One clock edge with the given bus cycle; strobe drops 1 ns after the edge.
  task automatic step(input logic s, input logic [7:0] id, input logic [7:0] d);
    IO_STRB  = s;
    PORT_ID  = id;
    OUT_PORT = d;
    @(posedge CLK);
    #1;
    IO_STRB = 1'b0;
  endtask

  task automatic stat_chk(input string name, input logic [7:0] exp_stat, input logic exp_intr);
    check({name, "_stat"}, IN_PORT, exp_stat);
    check({name, "_intr"}, 8'(INTR), 8'(exp_intr));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h40, 8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[1]  = '{1'b0, 8'h40, 8'h00, 8'hA5, 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 8'h77, 8'h00, 8'h00, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 8'h77, 8'hFF, 8'h00, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 8'h31, 8'h03, 8'h03, 8'hA5, 1'b0};
    vecs[5]  = '{1'b1, 8'h32, 8'h12, 8'h12, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 8'h31, 8'h55, 8'h03, 8'hA5, 1'b0};
    vecs[7]  = '{1'b1, 8'h33, 8'hF0, 8'hF0, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 8'h34, 8'h00, 8'h00, 8'hA5, 1'b0};
    vecs[9]  = '{1'b0, 8'h20, 8'h00, 8'h00, 8'hA5, 1'b0};
    vecs[10] = '{1'b1, 8'h40, 8'h3C, 8'h3C, 8'h3C, 1'b0};

    RESET = 1'b1; SWITCHES = 8'h00;
    IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;

    // Reset holds even with writes active
    step(1'b1, 8'h40, 8'hFF);
    step(1'b1, 8'h33, 8'hFF);
    check("rst_leds", LEDS, 8'h00);
    check("rst_intr", 8'(INTR), 8'h00);
    PORT_ID = 8'h34; #1;
    check("rst_stat", IN_PORT, 8'h00);
    PORT_ID = 8'h33; #1;
    check("rst_ctrl", IN_PORT, 8'h00);
    RESET = 1'b0;
    step(1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].strb, vecs[i].id, vecs[i].data);
      check($sformatf("vec%0d_in", i), IN_PORT, vecs[i].exp_in);
      check($sformatf("vec%0d_leds", i), LEDS, vecs[i].exp_leds);
      check($sformatf("vec%0d_intr", i), 8'(INTR), 8'(vecs[i].exp_intr));
    end

    // Auto-reload, reload=3: pending every 4 cycles, INTR one cycle later
    step(1'b1, 8'h31, 8'h03);
    step(1'b1, 8'h32, 8'h00);
    step(1'b1, 8'h33, 8'h07);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 8'h34, 8'h00);
      stat_chk($sformatf("ar_e%0d", k), 8'h00, 1'b0);
    end
    step(1'b0, 8'h34, 8'h00); stat_chk("ar_e4", 8'h01, 1'b0);
    step(1'b1, 8'h34, 8'h00); stat_chk("ar_e5clr", 8'h00, 1'b1);
    step(1'b0, 8'h34, 8'h00); stat_chk("ar_e6", 8'h00, 1'b0);
    step(1'b0, 8'h34, 8'h00); stat_chk("ar_e7", 8'h00, 1'b0);
    step(1'b0, 8'h34, 8'h00); stat_chk("ar_e8", 8'h01, 1'b0);
    step(1'b0, 8'h34, 8'h00); stat_chk("ar_e9", 8'h01, 1'b1);
    step(1'b1, 8'h33, 8'h00);
    step(1'b1, 8'h34, 8'h00);
    step(1'b0, 8'h34, 8'h00); stat_chk("ar_stop", 8'h00, 1'b0);

    // One-shot, reload=2: single expiry, EN self-clears
    step(1'b1, 8'h31, 8'h02);
    step(1'b1, 8'h33, 8'h05);
    step(1'b0, 8'h34, 8'h00); stat_chk("os_e1", 8'h00, 1'b0);
    step(1'b0, 8'h34, 8'h00); stat_chk("os_e2", 8'h00, 1'b0);
    step(1'b0, 8'h34, 8'h00); stat_chk("os_e3", 8'h01, 1'b0);
    step(1'b0, 8'h33, 8'h00);
    check("os_ctrl", IN_PORT, 8'h04);
    check("os_intr", 8'(INTR), 8'h01);
    step(1'b1, 8'h34, 8'h00);
    for (int k = 0; k < 6; k++) step(1'b0, 8'h34, 8'h00);
    stat_chk("os_quiet", 8'h00, 1'b0);
    step(1'b0, 8'h33, 8'h00);
    check("os_ctrl2", IN_PORT, 8'h04);

    // Switch rising edge through the synchronizer
    step(1'b1, 8'h33, 8'h08);
    step(1'b1, 8'h34, 8'h00);
    SWITCHES = 8'h10;
    step(1'b0, 8'h34, 8'h00); stat_chk("sw_e1", 8'h00, 1'b0);
    step(1'b0, 8'h34, 8'h00); stat_chk("sw_e2", 8'h00, 1'b0);
    step(1'b0, 8'h34, 8'h00); stat_chk("sw_e3", 8'h02, 1'b0);
    step(1'b0, 8'h20, 8'h00);
    check("sw_read", IN_PORT, 8'h10);
    check("sw_intr", 8'(INTR), 8'h01);
    step(1'b1, 8'h34, 8'h00);
    SWITCHES = 8'h00;
    for (int k = 0; k < 5; k++) step(1'b0, 8'h34, 8'h00);
    stat_chk("sw_fall", 8'h00, 1'b0);

    // Status clear coincident with expiry, reload=0 auto-reload
    step(1'b1, 8'h31, 8'h00);
    step(1'b1, 8'h33, 8'h07);
    step(1'b0, 8'h34, 8'h00); stat_chk("cc_e1", 8'h01, 1'b0);
    step(1'b0, 8'h34, 8'h00); stat_chk("cc_e2", 8'h01, 1'b1);
    step(1'b1, 8'h34, 8'h00); stat_chk("cc_clr", 8'h01, 1'b1);
    step(1'b0, 8'h34, 8'h00); stat_chk("cc_e4", 8'h01, 1'b1);

    // Reset mid-count with INTR high
    RESET = 1'b1;
    step(1'b0, 8'h34, 8'h00);
    RESET = 1'b0;
    stat_chk("mr", 8'h00, 1'b0);
    check("mr_leds", LEDS, 8'h00);
    PORT_ID = 8'h33; #1;
    check("mr_ctrl", IN_PORT, 8'h00);
    step(1'b0, 8'h34, 8'h00);
    stat_chk("mr_after", 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
